// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Main control FSM for the multi-cycle MIPS datapath. Each instruction is
// stepped through FETCH, DECODE and then an opcode-specific set of execute,
// memory and writeback states. The FSM drives the datapath enables and mux
// selects for each state, and it stalls on the memory ready handshake.
//
// Ports:
//   clk_i            clock, rising edge
//   rst_i            asynchronous active-low reset
//   instr_op_i       opcode from the instruction register (used in DECODE)
//   mem_ready_i      memory access completes this cycle
//   pc_write_o       unconditional PC load
//   pc_write_cond_o  PC load if ALU zero (beq)
//   i_or_d_o         memory address select: 0 = PC, 1 = ALUOut
//   mem_read_o       memory read request
//   mem_write_o      memory write request
//   ir_write_o       instruction register load
//   mem_to_reg_o     writeback source: 1 = MDR, 0 = ALUOut
//   pc_source_o      0 = ALU result, 1 = ALUOut, 2 = jump address
//   alu_op_o         0 = add, 1 = sub, 2 = R-type funct, 3 = slt
//   alu_src_a_o      0 = PC, 1 = rs
//   alu_src_b_o      0 = rt, 1 = 4, 2 = sext imm, 3 = sext imm << 2
//   reg_write_o      register file write
//   reg_dst_o        1 = rd, 0 = rt
//   illegal_op_o     one-cycle pulse in DECODE for an undefined opcode
//   state_o          current state encoding, for debug
// ---------------------------------------------------------------------------
module multicycle_control #(
  parameter int OP_W          = 6,
  parameter int ALUOP_W       = 3,
  parameter int STATE_W       = 4,
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [OP_W-1:0]    instr_op_i,
  input  logic               mem_ready_i,
  output logic               pc_write_o,
  output logic               pc_write_cond_o,
  output logic               i_or_d_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               ir_write_o,
  output logic               mem_to_reg_o,
  output logic [1:0]         pc_source_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic               alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic               reg_write_o,
  output logic               reg_dst_o,
  output logic               illegal_op_o,
  output logic [STATE_W-1:0] state_o
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EXEC   = 4'd6,
    R_WB     = 4'd7,
    BRANCH   = 4'd8,
    I_EXEC   = 4'd9,
    I_WB     = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(3);

  localparam logic HANDSHAKE_ON = (MEM_HANDSHAKE != 0);

  // State and latched opcode
  state_t     r_state;
  logic       r_active;
  logic [5:0] r_opcode;

  // Registered Moore outputs
  logic               r_fetch;
  logic               r_pcWrite;
  logic               r_pcWriteCond;
  logic               r_iOrD;
  logic               r_memRead;
  logic               r_memWrite;
  logic               r_memToReg;
  logic [1:0]         r_pcSource;
  logic [ALUOP_W-1:0] r_aluOp;
  logic               r_aluSrcA;
  logic [1:0]         r_aluSrcB;
  logic               r_regWrite;
  logic               r_regDst;

  // Decode helpers
  logic       w_ready;
  logic [5:0] w_opLow;
  logic       w_opUpperZero;
  logic       w_opLegal;
  logic [5:0] w_opForNext;

  // Next state and the Moore outputs that go with it
  state_t             w_nextState;
  logic               w_nFetch;
  logic               w_nPcWrite;
  logic               w_nPcWriteCond;
  logic               w_nIOrD;
  logic               w_nMemRead;
  logic               w_nMemWrite;
  logic               w_nMemToReg;
  logic [1:0]         w_nPcSource;
  logic [ALUOP_W-1:0] w_nAluOp;
  logic               w_nAluSrcA;
  logic [1:0]         w_nAluSrcB;
  logic               w_nRegWrite;
  logic               w_nRegDst;

  assign w_ready       = mem_ready_i | ~HANDSHAKE_ON;
  assign w_opLow       = instr_op_i[5:0];
  assign w_opUpperZero = ((instr_op_i >> 6) == '0);

  always_comb begin
    w_opLegal = 1'b0;
    if (w_opUpperZero) begin
      case (w_opLow)
        OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_SLTI, OP_LW, OP_SW: w_opLegal = 1'b1;
        default:                                                w_opLegal = 1'b0;
      endcase
    end
  end

  // The only transition that depends on the opcode of the instruction being
  // entered is DECODE, where the latch has not been loaded yet.
  assign w_opForNext = (r_state == DECODE) ? w_opLow : r_opcode;

  // Next-state logic. The first edge after reset release only activates the
  // FSM in FETCH, so no request is issued while the reset is still settling.
  always_comb begin
    w_nextState = FETCH;
    if (r_active) begin
      case (r_state)
        FETCH:    w_nextState = w_ready ? DECODE : FETCH;
        DECODE: begin
          if (!w_opLegal) begin
            w_nextState = FETCH;
          end else begin
            case (w_opLow)
              OP_RTYPE:        w_nextState = R_EXEC;
              OP_LW, OP_SW:    w_nextState = MEM_ADDR;
              OP_ADDI, OP_SLTI: w_nextState = I_EXEC;
              OP_BEQ:          w_nextState = BRANCH;
              OP_J:            w_nextState = JUMP;
              default:         w_nextState = FETCH;
            endcase
          end
        end
        MEM_ADDR: w_nextState = (r_opcode == OP_LW) ? MEM_RD : MEM_WR;
        MEM_RD:   w_nextState = w_ready ? MEM_WB : MEM_RD;
        MEM_WB:   w_nextState = FETCH;
        MEM_WR:   w_nextState = w_ready ? FETCH : MEM_WR;
        R_EXEC:   w_nextState = R_WB;
        R_WB:     w_nextState = FETCH;
        BRANCH:   w_nextState = FETCH;
        I_EXEC:   w_nextState = I_WB;
        I_WB:     w_nextState = FETCH;
        JUMP:     w_nextState = FETCH;
        default:  w_nextState = FETCH;
      endcase
    end
  end

  // Moore output table, evaluated for the state being entered so that the
  // outputs can be registered alongside the state.
  always_comb begin
    w_nFetch       = 1'b0;
    w_nPcWrite     = 1'b0;
    w_nPcWriteCond = 1'b0;
    w_nIOrD        = 1'b0;
    w_nMemRead     = 1'b0;
    w_nMemWrite    = 1'b0;
    w_nMemToReg    = 1'b0;
    w_nPcSource    = 2'd0;
    w_nAluOp       = ALU_ADD;
    w_nAluSrcA     = 1'b0;
    w_nAluSrcB     = 2'd0;
    w_nRegWrite    = 1'b0;
    w_nRegDst      = 1'b0;
    case (w_nextState)
      FETCH: begin
        w_nFetch   = 1'b1;
        w_nMemRead = 1'b1;
        w_nAluSrcB = 2'd1;
      end
      DECODE: begin
        w_nAluSrcB = 2'd3;
      end
      MEM_ADDR: begin
        w_nAluSrcA = 1'b1;
        w_nAluSrcB = 2'd2;
      end
      MEM_RD: begin
        w_nMemRead = 1'b1;
        w_nIOrD    = 1'b1;
      end
      MEM_WB: begin
        w_nRegWrite = 1'b1;
        w_nMemToReg = 1'b1;
      end
      MEM_WR: begin
        w_nMemWrite = 1'b1;
        w_nIOrD     = 1'b1;
      end
      R_EXEC: begin
        w_nAluSrcA = 1'b1;
        w_nAluOp   = ALU_FUNCT;
      end
      R_WB: begin
        w_nRegWrite = 1'b1;
        w_nRegDst   = 1'b1;
      end
      BRANCH: begin
        w_nAluSrcA     = 1'b1;
        w_nAluOp       = ALU_SUB;
        w_nPcWriteCond = 1'b1;
        w_nPcSource    = 2'd1;
      end
      I_EXEC: begin
        w_nAluSrcA = 1'b1;
        w_nAluSrcB = 2'd2;
        w_nAluOp   = (w_opForNext == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      I_WB: begin
        w_nRegWrite = 1'b1;
      end
      JUMP: begin
        w_nPcWrite  = 1'b1;
        w_nPcSource = 2'd2;
      end
      default: begin
        w_nFetch = 1'b0;
      end
    endcase
  end

  // State register, opcode latch and registered outputs. Reset clears
  // everything, so an instruction interrupted by reset issues no further
  // writes.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state       <= FETCH;
      r_active      <= 1'b0;
      r_opcode      <= 6'd0;
      r_fetch       <= 1'b0;
      r_pcWrite     <= 1'b0;
      r_pcWriteCond <= 1'b0;
      r_iOrD        <= 1'b0;
      r_memRead     <= 1'b0;
      r_memWrite    <= 1'b0;
      r_memToReg    <= 1'b0;
      r_pcSource    <= 2'd0;
      r_aluOp       <= ALU_ADD;
      r_aluSrcA     <= 1'b0;
      r_aluSrcB     <= 2'd0;
      r_regWrite    <= 1'b0;
      r_regDst      <= 1'b0;
    end else begin
      r_active      <= 1'b1;
      r_state       <= w_nextState;
      if (r_state == DECODE) begin
        r_opcode <= w_opLow;
      end
      r_fetch       <= w_nFetch;
      r_pcWrite     <= w_nPcWrite;
      r_pcWriteCond <= w_nPcWriteCond;
      r_iOrD        <= w_nIOrD;
      r_memRead     <= w_nMemRead;
      r_memWrite    <= w_nMemWrite;
      r_memToReg    <= w_nMemToReg;
      r_pcSource    <= w_nPcSource;
      r_aluOp       <= w_nAluOp;
      r_aluSrcA     <= w_nAluSrcA;
      r_aluSrcB     <= w_nAluSrcB;
      r_regWrite    <= w_nRegWrite;
      r_regDst      <= w_nRegDst;
    end
  end

  // IR and PC loads in FETCH wait for the memory to actually deliver the
  // instruction, so they follow ready within the cycle.
  assign ir_write_o      = r_fetch & w_ready;
  assign pc_write_o      = r_pcWrite | (r_fetch & w_ready);
  assign illegal_op_o    = (r_state == DECODE) & ~w_opLegal;

  assign pc_write_cond_o = r_pcWriteCond;
  assign i_or_d_o        = r_iOrD;
  assign mem_read_o      = r_memRead;
  assign mem_write_o     = r_memWrite;
  assign mem_to_reg_o    = r_memToReg;
  assign pc_source_o     = r_pcSource;
  assign alu_op_o        = r_aluOp;
  assign alu_src_a_o     = r_aluSrcA;
  assign alu_src_b_o     = r_aluSrcB;
  assign reg_write_o     = r_regWrite;
  assign reg_dst_o       = r_regDst;
  assign state_o         = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//
// Directed bench for multicycle_control. Each cycle the whole output bundle
// is packed into one vector and compared against a hand-written per-state
// table of expected controls.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MADDR = 2, S_MRD = 3, S_MWB = 4,
                 S_MWR = 5, S_REX = 6, S_RWB = 7, S_BR = 8, S_IEX = 9,
                 S_IWB = 10, S_J = 11;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [5:0] instr_op_i = 6'd0;
  logic       mem_ready_i = 1'b0;
  logic       pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o;
  logic       ir_write_o, mem_to_reg_o, alu_src_a_o, reg_write_o, reg_dst_o;
  logic       illegal_op_o;
  logic [1:0] pc_source_o, alu_src_b_o;
  logic [2:0] alu_op_o;
  logic [3:0] state_o;

  int         checkCount = 0;
  int         errorCount = 0;
  logic [5:0] curInstr = 6'd0;
  logic [5:0] noiseOp = 6'h3F;

  multicycle_control dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i),
    .mem_ready_i(mem_ready_i), .pc_write_o(pc_write_o),
    .pc_write_cond_o(pc_write_cond_o), .i_or_d_o(i_or_d_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .ir_write_o(ir_write_o), .mem_to_reg_o(mem_to_reg_o),
    .pc_source_o(pc_source_o), .alu_op_o(alu_op_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o),
    .illegal_op_o(illegal_op_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  // Watchdog so a broken sequence can never hang the run
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [21:0] observedOut();
    return {pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o,
            ir_write_o, mem_to_reg_o, pc_source_o, alu_op_o, alu_src_a_o,
            alu_src_b_o, reg_write_o, reg_dst_o, illegal_op_o, state_o};
  endfunction

  // Expected controls for one cycle in state st, for instruction op and ready
  function automatic logic [21:0] expOut(int st, logic [5:0] op, logic rdy);
    logic       pcw, pcwc, iod, mr, mw, irw, m2r, asa, rw, rd, ill;
    logic [1:0] ps, asb;
    logic [2:0] aop;
    {pcw, pcwc, iod, mr, mw, irw, m2r, asa, rw, rd, ill} = '0;
    ps = 2'd0; asb = 2'd0; aop = 3'd0;
    case (st)
      S_FETCH:  begin mr = 1'b1; irw = rdy; pcw = rdy; asb = 2'd1; end
      S_DECODE: begin
        asb = 2'd3;
        ill = !(op == 6'h00 || op == 6'h02 || op == 6'h04 || op == 6'h08 ||
                op == 6'h0A || op == 6'h23 || op == 6'h2B);
      end
      S_MADDR:  begin asa = 1'b1; asb = 2'd2; end
      S_MRD:    begin mr = 1'b1; iod = 1'b1; end
      S_MWB:    begin rw = 1'b1; m2r = 1'b1; end
      S_MWR:    begin mw = 1'b1; iod = 1'b1; end
      S_REX:    begin asa = 1'b1; aop = 3'd2; end
      S_RWB:    begin rw = 1'b1; rd = 1'b1; end
      S_BR:     begin asa = 1'b1; aop = 3'd1; pcwc = 1'b1; ps = 2'd1; end
      S_IEX:    begin asa = 1'b1; asb = 2'd2; aop = (op == 6'h0A) ? 3'd3 : 3'd0; end
      S_IWB:    begin rw = 1'b1; end
      S_J:      begin pcw = 1'b1; ps = 2'd2; end
      default:  begin end
    endcase
    return {pcw, pcwc, iod, mr, mw, irw, m2r, ps, aop, asa, asb, rw, rd, ill, 4'(st)};
  endfunction

  task automatic checkOutput(input string tag, input logic [21:0] observed,
                             input logic [21:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's inputs; the opcode is only meaningful in DECODE, so
  // every other cycle carries an illegal opcode to show it is ignored.
  task automatic applyStimulus(input int st, input logic rdy);
    instr_op_i  = (st == S_DECODE) ? curInstr : noiseOp;
    mem_ready_i = rdy;
  endtask

  task automatic stepCheck(input string tag, input int st, input logic rdy);
    applyStimulus(st, rdy);
    #1;
    checkOutput(tag, observedOut(), expOut(st, curInstr, rdy));
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    // Reset held across several edges: everything must be zero
    rst_i = 1'b0;
    mem_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #2;
    checkOutput("reset_a", observedOut(), 22'd0);
    @(posedge clk_i);
    #2;
    checkOutput("reset_b", observedOut(), 22'd0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #2;

    // lw with no wait states: 0,1,2,3,4
    curInstr = 6'h23;
    stepCheck("lw_fetch", S_FETCH, 1'b1);
    stepCheck("lw_decode", S_DECODE, 1'b1);
    stepCheck("lw_maddr", S_MADDR, 1'b1);
    stepCheck("lw_mrd", S_MRD, 1'b1);
    stepCheck("lw_mwb", S_MWB, 1'b1);

    // Fetch stall of 3 cycles, then sw with 2 wait cycles
    curInstr = 6'h2B;
    stepCheck("stall_f0", S_FETCH, 1'b0);
    stepCheck("stall_f1", S_FETCH, 1'b0);
    stepCheck("stall_f2", S_FETCH, 1'b0);
    stepCheck("sw_fetch", S_FETCH, 1'b1);
    stepCheck("sw_decode", S_DECODE, 1'b1);
    stepCheck("sw_maddr", S_MADDR, 1'b1);
    stepCheck("sw_mwr0", S_MWR, 1'b0);
    stepCheck("sw_mwr1", S_MWR, 1'b0);
    stepCheck("sw_mwr2", S_MWR, 1'b1);

    // R-type
    curInstr = 6'h00;
    stepCheck("r_fetch", S_FETCH, 1'b1);
    stepCheck("r_decode", S_DECODE, 1'b1);
    stepCheck("r_exec", S_REX, 1'b1);
    stepCheck("r_wb", S_RWB, 1'b1);

    // addi
    curInstr = 6'h08;
    stepCheck("addi_fetch", S_FETCH, 1'b1);
    stepCheck("addi_decode", S_DECODE, 1'b1);
    stepCheck("addi_exec", S_IEX, 1'b1);
    stepCheck("addi_wb", S_IWB, 1'b1);

    // slti
    curInstr = 6'h0A;
    stepCheck("slti_fetch", S_FETCH, 1'b1);
    stepCheck("slti_decode", S_DECODE, 1'b1);
    stepCheck("slti_exec", S_IEX, 1'b1);
    stepCheck("slti_wb", S_IWB, 1'b1);

    // beq
    curInstr = 6'h04;
    stepCheck("beq_fetch", S_FETCH, 1'b1);
    stepCheck("beq_decode", S_DECODE, 1'b1);
    stepCheck("beq_branch", S_BR, 1'b1);

    // j
    curInstr = 6'h02;
    stepCheck("j_fetch", S_FETCH, 1'b1);
    stepCheck("j_decode", S_DECODE, 1'b1);
    stepCheck("j_jump", S_J, 1'b1);

    // Illegal opcode: pulse in DECODE, then straight back to FETCH
    curInstr = 6'h3F;
    stepCheck("ill_fetch", S_FETCH, 1'b1);
    stepCheck("ill_decode", S_DECODE, 1'b1);

    // lw with a wait in MEM_RD, reset asserted during MEM_WB
    curInstr = 6'h23;
    stepCheck("lw2_fetch", S_FETCH, 1'b1);
    stepCheck("lw2_decode", S_DECODE, 1'b1);
    stepCheck("lw2_maddr", S_MADDR, 1'b1);
    stepCheck("lw2_mrd0", S_MRD, 1'b0);
    stepCheck("lw2_mrd1", S_MRD, 1'b1);
    applyStimulus(S_MWB, 1'b1);
    #1;
    checkOutput("lw2_mwb", observedOut(), expOut(S_MWB, curInstr, 1'b1));
    rst_i = 1'b0;
    #1;
    checkOutput("async_reset", observedOut(), 22'd0);
    @(posedge clk_i);
    #2;
    checkOutput("reset_hold", observedOut(), 22'd0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #2;

    // Restart from FETCH after reset
    curInstr = 6'h04;
    stepCheck("restart_fetch", S_FETCH, 1'b1);
    stepCheck("restart_decode", S_DECODE, 1'b1);
    stepCheck("restart_branch", S_BR, 1'b1);
    stepCheck("restart_next", S_FETCH, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
